hbuf_ddr3_pg_xfer: RTL and testbench
====================================

HBUF_DDR3_PG_XFER -- requirements
Module: hbuf_ddr3_pg_xfer

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
  P_PG_WORDS, 256, 128-bit words per page.
  P_ADDR_WIDTH, 28, app_addr and pg_addr width.
  P_ADDR_STEP, 8, app_addr increment per 128-bit word.
REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
  clk  in  1  DDR3 UI clock; the block's only clock.
  rst  in  1  synchronous, active-high reset.
  pg_req  in  1  page request from the hbuf controller; asynchronous to clk.
  pg_optype  in  1  0 = write page (dpram to DDR3), 1 = read page (DDR3 to dpram).
  pg_addr  in  28  app_addr of page word 0.
  pg_ack  out  1  four-phase acknowledge.
  wr_dpram_rd_addr  out  8  outbound page dpram read address.
  wr_dpram_dout  in  128  outbound page dpram data, 1-cycle read latency.
  rd_dpram_wren  out  1  inbound page dpram write enable.
  rd_dpram_addr  out  8  inbound page dpram write address.
  rd_dpram_din  out  128  inbound page dpram write data.
  app_en  out  1  MIG command valid.
  app_cmd  out  3  MIG command: 3'b000 = write, 3'b001 = read.
  app_addr  out  28  MIG command address.
  app_rdy  in  1  MIG command accept.
  app_wdf_wren  out  1  MIG write-data valid.
  app_wdf_end  out  1  MIG write-data end; equals app_wdf_wren.
  app_wdf_data  out  128  MIG write data.
  app_wdf_rdy  in  1  MIG write-data accept.
  app_rd_data  in  128  MIG read data.
  app_rd_data_valid  in  1  MIG read data valid.
  busy  out  1  high in every state except IDLE.
  n_pg_xfer  out  16  completed-transfer count; wraps at 16'hFFFF.

Function
REQ-003 pg_req SHALL pass through a two-flop synchronizer; pg_req_s denotes its output.
REQ-004 FSM states SHALL be IDLE, WR, RD, ACK.
REQ-005 In IDLE with pg_req_s=1 and pg_ack=0, the block SHALL latch pg_optype and pg_addr and enter WR (optype 0) or RD (optype 1).
REQ-006 A command SHALL be accepted on a cycle where app_en and app_rdy are both high; write data SHALL be accepted on a cycle where app_wdf_wren and app_wdf_rdy are both high.
REQ-007 The command and write-data streams SHALL advance independently; each SHALL hold its outputs stable until accepted.
REQ-008 The k-th command of a page SHALL carry app_addr = latched pg_addr + k*P_ADDR_STEP, truncated to P_ADDR_WIDTH (wraps modulo 2^28).
REQ-009 WR: the block SHALL read dpram words 0..255 in order through a skid/holding register, absorbing the 1-cycle read latency.
REQ-010 WR: app_wdf_data for beat k SHALL equal dpram word k, with no bubble while app_wdf_rdy stays high.
REQ-011 WR: the block SHALL issue 256 write commands; it SHALL enter ACK only when both 256 commands and 256 data beats have been accepted.
REQ-012 RD: the block SHALL issue 256 read commands.
REQ-013 RD: the j-th app_rd_data_valid beat SHALL produce rd_dpram_wren=1, rd_dpram_addr=j, rd_dpram_din=app_rd_data in the next cycle.
REQ-014 RD: the block SHALL enter ACK after the 256th returned beat; read data arriving outside RD SHALL be ignored.
REQ-015 ACK: pg_ack SHALL be 1; on pg_req_s=0 the block SHALL drive pg_ack to 0, increment n_pg_xfer, and return to IDLE.
REQ-016 A pg_req_s still high in IDLE with pg_ack=0 (the next request) SHALL start a new transfer with no extra idle cycle.
REQ-017 app_rdy or app_wdf_rdy held low for any duration SHALL stall only the affected stream; no word SHALL be dropped or duplicated.

Reset
REQ-018 rst SHALL force state IDLE, and force to 0: pg_ack, app_en, app_wdf_wren, rd_dpram_wren, busy, n_pg_xfer, all address counters, and the synchronizer flops.
REQ-019 Reset mid-transfer SHALL abandon the page without acknowledging it; a still-high pg_req SHALL restart the transfer from word 0 after reset.

Verification
REQ-020 Write page, pg_addr=0x100, dpram word k = k, app_rdy and app_wdf_rdy held high -> 256 write commands at addresses 0x100..0x8F8 step 8, data 0..255 in order, then pg_ack=1, and n_pg_xfer=1 after pg_req falls.
REQ-021 Read page with the model returning word j = ~j after a 20-cycle delay -> rd_dpram_addr 0..255 written with ~j, then pg_ack=1.
REQ-022 Random app_rdy and app_wdf_rdy (50% duty) during a write -> data sequence identical to REQ-020; exactly 256 of each handshake.
REQ-023 pg_addr=0xFFFFFF8 write -> second command address 0x0000000 (wrap).
REQ-024 rst asserted at beat 100 of a write with pg_req held high -> pg_ack stays 0; the restarted transfer begins at address pg_addr and completes 256 beats.
REQ-025 Three back-to-back four-phase requests (write, read, write) -> n_pg_xfer=3 and busy=0 at the end.

Source files
------------

// File: rtl/hbuf_ddr3_pg_xfer.sv
// Moves one page between the hbuf dpram pair and the DDR3 MIG user interface
// under a four-phase pg_req/pg_ack handshake from the hbuf controller.
//
//   state | meaning
//   IDLE  | waiting for a synchronized page request
//   WR    | dpram -> DDR3: issue write commands and stream write data
//   RD    | DDR3 -> dpram: issue read commands and collect returned beats
//   ACK   | page done, pg_ack high until the request is withdrawn
module hbuf_ddr3_pg_xfer #(
    parameter int P_PG_WORDS   = 256,
    parameter int P_ADDR_WIDTH = 28,
    parameter int P_ADDR_STEP  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pg_req,
    input  logic                            pg_optype,
    input  logic [P_ADDR_WIDTH-1:0]         pg_addr,
    output logic                            pg_ack,
    output logic [$clog2(P_PG_WORDS)-1:0]   wr_dpram_rd_addr,
    input  logic [127:0]                    wr_dpram_dout,
    output logic                            rd_dpram_wren,
    output logic [$clog2(P_PG_WORDS)-1:0]   rd_dpram_addr,
    output logic [127:0]                    rd_dpram_din,
    output logic                            app_en,
    output logic [2:0]                      app_cmd,
    output logic [P_ADDR_WIDTH-1:0]         app_addr,
    input  logic                            app_rdy,
    output logic                            app_wdf_wren,
    output logic                            app_wdf_end,
    output logic [127:0]                    app_wdf_data,
    input  logic                            app_wdf_rdy,
    input  logic [127:0]                    app_rd_data,
    input  logic                            app_rd_data_valid,
    output logic                            busy,
    output logic [15:0]                     n_pg_xfer
);

    localparam int AW = $clog2(P_PG_WORDS);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]           LAST = CW'(P_PG_WORDS);
    localparam logic [P_ADDR_WIDTH-1:0] STEP = P_ADDR_WIDTH'(P_ADDR_STEP);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_ACK} state_t;

    state_t                  state_q, state_d;
    logic                    req_meta_q, req_sync_q;
    logic [P_ADDR_WIDTH-1:0] cmd_addr_q;
    logic [CW-1:0]           cmd_cnt_q, fetch_cnt_q, wdf_cnt_q, rx_cnt_q;
    logic                    rd_pend_q, hold_vld_q, skid_vld_q;
    logic [127:0]            hold_q, skid_q;
    logic                    rd_wren_q;
    logic [AW-1:0]           rd_addr_q;
    logic [127:0]            rd_din_q;
    logic [15:0]             n_xfer_q;

    logic       start, finish, cmd_fire, wdf_fire, fetch_en, rx_fire;
    logic [1:0] occ;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: if (req_sync_q) begin
                start   = 1'b1;
                state_d = pg_optype ? S_RD : S_WR;
            end
            S_WR:   if (cmd_cnt_q == LAST && wdf_cnt_q == LAST) state_d = S_ACK;
            S_RD:   if (cmd_cnt_q == LAST && rx_cnt_q == LAST)  state_d = S_ACK;
            S_ACK:  if (!req_sync_q) begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign app_en   = (state_q == S_WR || state_q == S_RD) && (cmd_cnt_q != LAST);
    assign app_cmd  = (state_q == S_RD) ? 3'b001 : 3'b000;
    assign app_addr = cmd_addr_q;
    assign cmd_fire = app_en & app_rdy;

    assign app_wdf_wren = hold_vld_q;
    assign app_wdf_end  = hold_vld_q;
    assign app_wdf_data = hold_q;
    assign wdf_fire     = hold_vld_q & app_wdf_rdy;

    // Words buffered next cycle (output + skid + read in flight) must stay within two.
    assign occ      = 2'(hold_vld_q) + 2'(skid_vld_q) + 2'(rd_pend_q) - 2'(wdf_fire);
    assign fetch_en = (state_q == S_WR) && (fetch_cnt_q != LAST) && (occ < 2'd2);
    assign wr_dpram_rd_addr = fetch_cnt_q[AW-1:0];

    assign rx_fire = (state_q == S_RD) && app_rd_data_valid && (rx_cnt_q != LAST);

    assign rd_dpram_wren = rd_wren_q;
    assign rd_dpram_addr = rd_addr_q;
    assign rd_dpram_din  = rd_din_q;
    assign pg_ack        = (state_q == S_ACK);
    assign busy          = (state_q != S_IDLE);
    assign n_pg_xfer     = n_xfer_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_meta_q  <= 1'b0;
            req_sync_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_cnt_q   <= '0;
            fetch_cnt_q <= '0;
            wdf_cnt_q   <= '0;
            rx_cnt_q    <= '0;
            rd_pend_q   <= 1'b0;
            hold_vld_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            hold_q      <= '0;
            skid_q      <= '0;
            rd_wren_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_din_q    <= '0;
            n_xfer_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_meta_q <= pg_req;
            req_sync_q <= req_meta_q;

            if (state_q == S_IDLE) begin
                cmd_cnt_q   <= '0;
                fetch_cnt_q <= '0;
                wdf_cnt_q   <= '0;
                rx_cnt_q    <= '0;
                rd_pend_q   <= 1'b0;
                hold_vld_q  <= 1'b0;
                skid_vld_q  <= 1'b0;
                if (start) cmd_addr_q <= pg_addr;
            end else begin
                if (cmd_fire) begin
                    cmd_cnt_q  <= cmd_cnt_q + 1'b1;
                    cmd_addr_q <= cmd_addr_q + STEP;
                end
                if (wdf_fire) wdf_cnt_q   <= wdf_cnt_q + 1'b1;
                if (fetch_en) fetch_cnt_q <= fetch_cnt_q + 1'b1;
                if (rx_fire)  rx_cnt_q    <= rx_cnt_q + 1'b1;
                rd_pend_q <= fetch_en;

                // Output register refills from the skid first so word order is kept.
                if (!hold_vld_q || wdf_fire) begin
                    if (skid_vld_q) begin
                        hold_q     <= skid_q;
                        hold_vld_q <= 1'b1;
                        skid_vld_q <= rd_pend_q;
                        if (rd_pend_q) skid_q <= wr_dpram_dout;
                    end else if (rd_pend_q) begin
                        hold_q     <= wr_dpram_dout;
                        hold_vld_q <= 1'b1;
                    end else begin
                        hold_vld_q <= 1'b0;
                    end
                end else if (rd_pend_q) begin
                    skid_q     <= wr_dpram_dout;
                    skid_vld_q <= 1'b1;
                end
            end

            rd_wren_q <= rx_fire;
            if (rx_fire) begin
                rd_addr_q <= rx_cnt_q[AW-1:0];
                rd_din_q  <= app_rd_data;
            end
            if (finish) n_xfer_q <= n_xfer_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_hbuf_ddr3_pg_xfer.sv
// Scoreboard bench for hbuf_ddr3_pg_xfer: a MIG/dpram model in a monitor process
// checks every handshake against expectations queued when each page is requested.
module tb_hbuf_ddr3_pg_xfer;

    logic         clk, rst, pg_req, pg_optype;
    logic [27:0]  pg_addr;
    logic         pg_ack;
    logic [7:0]   wr_dpram_rd_addr;
    logic [127:0] wr_dpram_dout;
    logic         rd_dpram_wren;
    logic [7:0]   rd_dpram_addr;
    logic [127:0] rd_dpram_din;
    logic         app_en;
    logic [2:0]   app_cmd;
    logic [27:0]  app_addr;
    logic         app_rdy, app_wdf_wren, app_wdf_end;
    logic [127:0] app_wdf_data;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid, busy;
    logic [15:0]  n_pg_xfer;

    hbuf_ddr3_pg_xfer dut (
        .clk(clk), .rst(rst), .pg_req(pg_req), .pg_optype(pg_optype), .pg_addr(pg_addr),
        .pg_ack(pg_ack), .wr_dpram_rd_addr(wr_dpram_rd_addr), .wr_dpram_dout(wr_dpram_dout),
        .rd_dpram_wren(rd_dpram_wren), .rd_dpram_addr(rd_dpram_addr), .rd_dpram_din(rd_dpram_din),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .busy(busy), .n_pg_xfer(n_pg_xfer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0;
    logic [30:0]  exp_cmd[$];
    logic [127:0] exp_wdf[$];
    logic [135:0] exp_rd[$];
    int           ret_due[$];
    logic [127:0] ret_dat[$];
    logic [127:0] dpram[256];
    logic [27:0]  cur_base = '0;
    bit           rand_rdy = 1'b0;
    int           stray_req = 0, stray_done = 0;
    int           cmd_hs = 0, wdf_hs = 0, rd_hs = 0, exp_xfers = 0;
    int           beat_cyc[4096];
    logic [27:0]  cmd_log[4096];

    function automatic void chk(string name, logic [159:0] act, logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // dpram with one cycle read latency
    always @(posedge clk) wr_dpram_dout <= dpram[wr_dpram_rd_addr];

    // Monitor + MIG model: drive inputs for the coming edge, then score handshakes.
    initial begin
        logic        prev_valid;
        logic [27:0] off;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            prev_valid = app_rd_data_valid;
            if (rd_dpram_wren) begin
                rd_hs++;
                chk("rd_latency", 160'(prev_valid), 160'(1'b1));
                if (exp_rd.size() == 0) begin
                    n_chk++;
                    $display("FAIL rd_extra: got write addr %0h data %0h, expected none", rd_dpram_addr, rd_dpram_din);
                end else chk("rd_word", 160'({rd_dpram_addr, rd_dpram_din}), 160'(exp_rd.pop_front()));
            end
            if (rst) begin
                ret_due.delete();
                ret_dat.delete();
            end
            app_rdy     = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            app_wdf_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stray_done != stray_req) begin
                app_rd_data_valid = 1'b1;
                app_rd_data = {$urandom, $urandom, $urandom, $urandom};
                stray_done++;
            end else if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
                app_rd_data_valid = 1'b1;
                app_rd_data = ret_dat.pop_front();
                void'(ret_due.pop_front());
            end else begin
                app_rd_data_valid = 1'b0;
            end
            if (!rst && app_en && app_rdy) begin
                if (cmd_hs < 4096) cmd_log[cmd_hs] = app_addr;
                cmd_hs++;
                if (exp_cmd.size() == 0) begin
                    n_chk++;
                    $display("FAIL cmd_extra: got cmd %0h addr %0h, expected none", app_cmd, app_addr);
                end else chk("cmd", 160'({app_cmd, app_addr}), 160'(exp_cmd.pop_front()));
                if (app_cmd == 3'b001) begin
                    off = app_addr - cur_base;
                    ret_due.push_back(cyc + 20);
                    ret_dat.push_back(~(128'(off >> 3)));
                end
            end
            if (!rst && app_wdf_wren && app_wdf_rdy) begin
                if (wdf_hs < 4096) beat_cyc[wdf_hs] = cyc;
                wdf_hs++;
                chk("wdf_end", 160'(app_wdf_end), 160'(1'b1));
                if (exp_wdf.size() == 0) begin
                    n_chk++;
                    $display("FAIL wdf_extra: got data %0h, expected none", app_wdf_data);
                end else chk("wdf_data", 160'(app_wdf_data), 160'(exp_wdf.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, output bit got);
        got = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            tick(1);
            if (pg_ack === lvl) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_page(input logic op, input logic [27:0] addr);
        cur_base = addr;
        for (int k = 0; k < 256; k++) begin
            exp_cmd.push_back({op ? 3'b001 : 3'b000, addr + 28'(k * 8)});
            if (!op) exp_wdf.push_back(dpram[k]);
            else     exp_rd.push_back({8'(k), ~(128'(k))});
        end
    endtask

    task automatic finish_page();
        bit got;
        wait_ack(1'b1, got);
        chk("ack_rise", 160'(got), 160'(1'b1));
        tick(2);
        chk("busy_in_ack", 160'(busy), 160'(1'b1));
        chk("cmd_drained", 160'(exp_cmd.size()), 160'(0));
        chk("wdf_drained", 160'(exp_wdf.size()), 160'(0));
        chk("rd_drained", 160'(exp_rd.size()), 160'(0));
        pg_req = 1'b0;
        wait_ack(1'b0, got);
        chk("ack_fall", 160'(got), 160'(1'b1));
        exp_xfers++;
        chk("n_pg_xfer", 160'(n_pg_xfer), 160'(exp_xfers));
        chk("busy_idle", 160'(busy), 160'(1'b0));
    endtask

    task automatic run_page(input logic op, input logic [27:0] addr);
        push_page(op, addr);
        pg_optype = op;
        pg_addr   = addr;
        pg_req    = 1'b1;
        finish_page();
    endtask

    task automatic fill_random();
        for (int k = 0; k < 256; k++) dpram[k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  wb, cb, rb;
        bit  got;
        rst = 1'b1; pg_req = 1'b0; pg_optype = 1'b0; pg_addr = '0;
        for (int k = 0; k < 256; k++) dpram[k] = 128'(k);
        tick(4);
        rst = 1'b0;
        tick(1);
        chk("rst_pg_ack", 160'(pg_ack), 160'(1'b0));
        chk("rst_busy", 160'(busy), 160'(1'b0));
        chk("rst_n_pg_xfer", 160'(n_pg_xfer), 160'(16'd0));
        chk("rst_app_en", 160'(app_en), 160'(1'b0));
        chk("rst_wdf_wren", 160'(app_wdf_wren), 160'(1'b0));
        chk("rst_rd_wren", 160'(rd_dpram_wren), 160'(1'b0));
        chk("rst_rd_addr", 160'(wr_dpram_rd_addr), 160'(8'd0));

        // write page, word k = k, ready held high: no bubbles
        wb = wdf_hs; cb = cmd_hs;
        run_page(1'b0, 28'h100);
        chk("wdf_no_bubble", 160'(beat_cyc[wb + 255] - beat_cyc[wb]), 160'(255));
        chk("last_cmd_addr", 160'(cmd_log[cb + 255]), 160'(28'h8F8));

        // read data outside RD is dropped
        rb = rd_hs;
        stray_req++;
        tick(5);
        chk("stray_ignored", 160'(rd_hs - rb), 160'(0));

        // read page, model returns ~j after 20 cycles
        run_page(1'b1, 28'h200);

        // random ready on both streams during a write
        fill_random();
        rand_rdy = 1'b1;
        wb = wdf_hs; cb = cmd_hs;
        run_page(1'b0, 28'h0123450);
        chk("rand_wdf_count", 160'(wdf_hs - wb), 160'(256));
        chk("rand_cmd_count", 160'(cmd_hs - cb), 160'(256));
        rand_rdy = 1'b0;

        // address wrap
        cb = cmd_hs;
        run_page(1'b0, 28'hFFFFFF8);
        chk("wrap_addr0", 160'(cmd_log[cb]), 160'(28'hFFFFFF8));
        chk("wrap_addr1", 160'(cmd_log[cb + 1]), 160'(28'h0000000));

        // reset at beat 100 with pg_req held high
        fill_random();
        push_page(1'b0, 28'h0ABC000);
        pg_optype = 1'b0; pg_addr = 28'h0ABC000; pg_req = 1'b1;
        wb = wdf_hs; got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if (wdf_hs >= wb + 100) begin
                got = 1'b1;
                break;
            end
        end
        chk("beat100_reached", 160'(got), 160'(1'b1));
        chk("no_ack_before_rst", 160'(pg_ack), 160'(1'b0));
        rst = 1'b1;
        tick(1);
        exp_cmd.delete(); exp_wdf.delete(); exp_rd.delete();
        push_page(1'b0, 28'h0ABC000);
        tick(1);
        rst = 1'b0;
        exp_xfers = 0;
        chk("mid_rst_busy", 160'(busy), 160'(1'b0));
        chk("mid_rst_ack", 160'(pg_ack), 160'(1'b0));
        chk("mid_rst_count", 160'(n_pg_xfer), 160'(16'd0));
        cb = cmd_hs; wb = wdf_hs;
        finish_page();
        chk("restart_addr", 160'(cmd_log[cb]), 160'(28'h0ABC000));
        chk("restart_beats", 160'(wdf_hs - wb), 160'(256));

        // three back-to-back four-phase requests from a fresh reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_xfers = 0;
        rand_rdy = 1'b1;
        fill_random();
        run_page(1'b0, 28'h0400000);
        run_page(1'b1, 28'h0800000);
        fill_random();
        run_page(1'b0, 28'h0C00000);
        tick(2);
        chk("b2b_n_pg_xfer", 160'(n_pg_xfer), 160'(16'd3));
        chk("b2b_busy", 160'(busy), 160'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
